tri_addrcmp_seq: RTL and testbench
==================================

# tri_addrcmp_seq

Time-multiplexed address-compare sequencer: holds ENTRIES programmable 36-bit compare entries and scans one entry per cycle against a latched request address, using a single 36-bit equality compare unit. It returns a hit vector and the lowest hit index through a valid/ready response port. It sits beside debug/watchpoint and snoop-filter logic, where a full parallel comparator bank costs too much area.

## Interface
- ENTRIES, 4, number of compare entries; legal range 2..16
- IDXW, 2, index width; must equal clog2(ENTRIES)
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset; synchronous, active-high
- wr_val  in  1  entry write strobe
- wr_idx  in  IDXW  entry to write
- wr_addr  in  36  compare address (bits 0:35, bit 0 MSB)
- wr_lsb_en  in  1  entry includes addr bit 35 in the compare when 1; ignores it when 0
- wr_ent_val  in  1  entry valid bit to store
- req_val  in  1  compare request
- req_addr  in  36  address to compare
- req_rdy  out  1  request accepted when req_val & req_rdy
- flush  in  1  abort an in-flight scan or drop a pending response
- rsp_val  out  1  response valid
- rsp_rdy  in  1  response consumed when rsp_val & rsp_rdy
- rsp_hit  out  1  OR of rsp_hit_vec
- rsp_hit_vec  out  ENTRIES  per-entry hit, bit i = entry i
- rsp_idx  out  IDXW  lowest set index in rsp_hit_vec; 0 when no hit
- busy  out  1  state != IDLE

## Operation
- Entry storage: per entry addr[0:35], lsb_en, ent_val; all cleared by rst.
- The compare unit is one instance of the team's 36-bit address compare (enable_lsb = lsb_en of the selected entry).
- Entry hit = ent_val & compare eq.
- FSM states IDLE, SCAN, RESP.
  - IDLE: req_rdy=1. On accept: latch req_addr, clear the hit vector, set scan index to 0, go to SCAN.
  - SCAN: compare entry[idx] against the latched address. Write the hit into vec[idx] at the edge. Increment idx. At idx = ENTRIES-1, go to RESP.
  - RESP: rsp_val=1, with rsp_hit_vec, rsp_hit and rsp_idx stable. On rsp_rdy, go to IDLE.
- Invalid entries still consume their scan cycle; the latency is deterministic.
- Entry writes are accepted in any state. A write lands at the edge and is visible to the compare from the next cycle. A same-cycle write to the entry being scanned does not affect that compare.
- flush in SCAN or RESP: go to IDLE at the edge; no response is produced; entries are unaffected. flush in IDLE: no effect. A flush coinciding with rsp_rdy counts as a flush (no handshake is counted).
- rst mid-scan: FSM to IDLE, all entries invalidated, outputs at reset values next cycle.
- No new request is accepted until the response handshake completes (req_rdy=0 in SCAN/RESP).

## Timing
- Reset values: req_rdy=1, rsp_val=0, rsp_hit=0, rsp_hit_vec=0, rsp_idx=0, busy=0.
- Request accepted at the edge ending cycle 0. SCAN occupies cycles 1..ENTRIES. rsp_val is first high in cycle ENTRIES+1.
- Response outputs are registered and held while rsp_val & !rsp_rdy.
- req_rdy is high again in the cycle after the response handshake. Back-to-back request throughput is one per ENTRIES+2 cycles with rsp_rdy tied high.
- rsp_idx uses a priority encode of the hit vector, registered on entry to RESP.

## Configuration
- TRI_ADDRCMP_SEQ_EARLY_EXIT_EN defined: in SCAN, a hit on entry i goes to RESP at that edge.
  - rsp_hit_vec then has only bit i set; entries above i are not compared; rsp_idx = i.
  - Latency is i+2 cycles from accept to rsp_val.
- Not defined: every entry is always scanned; the full hit vector is reported and latency is fixed at ENTRIES+1.

## Test plan
- Reset, then ENTRIES=4; program entry2 = 36'h0_1234_5678 (valid, lsb_en=1). Request 36'h0_1234_5678 -> rsp_val in cycle 5, rsp_hit_vec=4'b0100, rsp_idx=2, rsp_hit=1.
- Entries 1 and 3 both = 36'hA_BCDE_F012 (valid) -> full scan gives vec=4'b1010, rsp_idx=1. With EARLY_EXIT_EN: vec=4'b0010, rsp_val in cycle 3.
- Entry0 = 36'h0_0000_0010 with lsb_en=0; request 36'h0_0000_0011 -> hit on entry0. Same with lsb_en=1 -> rsp_hit=0, rsp_idx=0.
- Hold rsp_rdy=0 for 3 cycles in RESP, with req_val=1 throughout -> response stable, req_rdy=0. Release rsp_rdy -> req_rdy=1 next cycle, new request accepted.
- flush in SCAN cycle 2 -> no rsp_val, busy=0 next cycle. rst asserted in SCAN -> all entries invalid, and a following request matching a former entry gives rsp_hit=0.
- Write entry3 in scan cycle 1 with an address matching the in-flight request -> hit reported (entry3 is compared in cycle 4). Write entry0 in cycle 1 -> no hit on entry0 (already scanned).

Source files
------------

// File: rtl/tri_addrcmp_seq.sv
// tri_addrcmp_seq: time-multiplexed address-compare sequencer, one entry per cycle through one compare unit.
// Optional TRI_ADDRCMP_SEQ_EARLY_EXIT_EN: stop the scan at the first hit.
module tri_addrcmp36 (
    input  logic [0:35] a,
    input  logic [0:35] b,
    input  logic        enable_lsb,
    output logic        eq
);
    assign eq = (a[0:34] == b[0:34]) & (!enable_lsb | (a[35] == b[35]));
endmodule

module tri_addrcmp_seq #(
    parameter int ENTRIES = 4,
    parameter int IDXW    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_val,
    input  logic [IDXW-1:0]     wr_idx,
    input  logic [0:35]         wr_addr,
    input  logic                wr_lsb_en,
    input  logic                wr_ent_val,
    input  logic                req_val,
    input  logic [0:35]         req_addr,
    output logic                req_rdy,
    input  logic                flush,
    output logic                rsp_val,
    input  logic                rsp_rdy,
    output logic                rsp_hit,
    output logic [ENTRIES-1:0]  rsp_hit_vec,
    output logic [IDXW-1:0]     rsp_idx,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t              state, state_n;
    logic [0:35]         ent_addr [ENTRIES];
    logic [ENTRIES-1:0]  ent_lsb, ent_vld;
    logic [0:35]         addr_q;
    logic [IDXW-1:0]     idx, idx_q;
    logic [ENTRIES-1:0]  vec, vec_n;
    logic                eq, hit, last, done, accept;

    function automatic logic [IDXW-1:0] penc(input logic [ENTRIES-1:0] v);
        logic [IDXW-1:0] p;
        p = '0;
        for (int i = ENTRIES - 1; i >= 0; i--)
            if (v[i]) p = IDXW'(i);
        return p;
    endfunction

    tri_addrcmp36 u_cmp (
        .a          (ent_addr[idx]),
        .b          (addr_q),
        .enable_lsb (ent_lsb[idx]),
        .eq         (eq)
    );

    assign hit    = ent_vld[idx] & eq;
    assign last   = idx == IDXW'(ENTRIES - 1);
    assign vec_n  = vec | (ENTRIES'(hit) << idx);
    assign accept = (state == IDLE) & req_val;
`ifdef TRI_ADDRCMP_SEQ_EARLY_EXIT_EN
    assign done   = (state == SCAN) & (last | hit);
`else
    assign done   = (state == SCAN) & last;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (accept) state_n = SCAN;
        if (done) state_n = RESP;
        if ((state == RESP) & rsp_rdy) state_n = IDLE;
        if (flush & (state != IDLE)) state_n = IDLE;
    end

    // Writes land at the edge, so a compare always sees the pre-write entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) ent_addr[i] <= '0;
            ent_lsb <= '0;
            ent_vld <= '0;
            addr_q  <= '0;
            idx     <= '0;
            idx_q   <= '0;
            vec     <= '0;
        end else begin
            if (wr_val) begin
                ent_addr[wr_idx] <= wr_addr;
                ent_lsb[wr_idx]  <= wr_lsb_en;
                ent_vld[wr_idx]  <= wr_ent_val;
            end
            if (accept) begin
                addr_q <= req_addr;
                vec    <= '0;
                idx    <= '0;
            end
            if (state == SCAN) begin
                vec <= vec_n;
                idx <= idx + 1'b1;
            end
            if (done) idx_q <= penc(vec_n);
        end
    end

    assign req_rdy     = state == IDLE;
    assign busy        = state != IDLE;
    assign rsp_val     = state == RESP;
    assign rsp_hit_vec = rsp_val ? vec : '0;
    assign rsp_hit     = |rsp_hit_vec;
    assign rsp_idx     = rsp_val ? idx_q : '0;
endmodule

// File: tb/tb_tri_addrcmp_seq.sv
// tb_tri_addrcmp_seq: directed checks of the address-compare sequencer with ENTRIES=4.
module tb_tri_addrcmp_seq;
    logic        clk = 0, rst = 1;
    logic        wr_val = 0, wr_lsb_en = 0, wr_ent_val = 0;
    logic [1:0]  wr_idx = 0;
    logic [0:35] wr_addr = 0, req_addr = 0;
    logic        req_val = 0, flush = 0, rsp_rdy = 0;
    logic        req_rdy, rsp_val, rsp_hit, busy;
    logic [3:0]  rsp_hit_vec;
    logic [1:0]  rsp_idx;
    int          checks = 0, failures = 0;

    localparam logic [0:35] A1 = 36'h0_1234_5678, A2 = 36'hA_BCDE_F012;
    localparam logic [0:35] AX = 36'h5_5555_5555, AY = 36'h6_6666_6666, AZ = 36'h7_0000_0007;

    tri_addrcmp_seq #(.ENTRIES(4), .IDXW(2)) dut (
        .clk(clk), .rst(rst), .wr_val(wr_val), .wr_idx(wr_idx), .wr_addr(wr_addr),
        .wr_lsb_en(wr_lsb_en), .wr_ent_val(wr_ent_val), .req_val(req_val), .req_addr(req_addr),
        .req_rdy(req_rdy), .flush(flush), .rsp_val(rsp_val), .rsp_rdy(rsp_rdy), .rsp_hit(rsp_hit),
        .rsp_hit_vec(rsp_hit_vec), .rsp_idx(rsp_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic write_entry(input logic [1:0] i, input logic [0:35] a, input logic l, input logic v);
        wr_val = 1; wr_idx = i; wr_addr = a; wr_lsb_en = l; wr_ent_val = v;
        @(negedge clk);
        wr_val = 0;
    endtask

    // Called at the negedge of scan cycle 1; returns the cycle index of the first rsp_val.
    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_val && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_req(input logic [0:35] a, output int lat);
        req_val = 1; req_addr = a;
        @(negedge clk);
        req_val = 0;
        wait_rsp(lat);
    endtask

    task automatic ack;
        rsp_rdy = 1;
        @(negedge clk);
        rsp_rdy = 0;
    endtask

    task automatic check_rsp(input string name, input int lat, input int elat,
                             input logic [3:0] evec, input logic [1:0] eidx);
        checks++;
        if (lat !== elat) begin failures++; $display("FAIL %s latency got %0d want %0d", name, lat, elat); end
        checks++;
        if (rsp_hit_vec !== evec) begin failures++; $display("FAIL %s vec got %b want %b", name, rsp_hit_vec, evec); end
        checks++;
        if (rsp_idx !== eidx) begin failures++; $display("FAIL %s idx got %0d want %0d", name, rsp_idx, eidx); end
        checks++;
        if (rsp_hit !== |evec) begin failures++; $display("FAIL %s hit got %b want %b", name, rsp_hit, |evec); end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        checks++;
        if ({req_rdy, rsp_val, rsp_hit, rsp_hit_vec, rsp_idx, busy} !== 10'b1_0_0_0000_00_0) begin
            failures++;
            $display("FAIL reset outputs got %b want 1000000000",
                     {req_rdy, rsp_val, rsp_hit, rsp_hit_vec, rsp_idx, busy});
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_single_hit;
        int lat;
        write_entry(2, A1, 1, 1);
        do_req(A1, lat);
        check_rsp("single", lat, 5, 4'b0100, 2'd2);
        ack();
        checks++;
        if (req_rdy !== 1 || rsp_val !== 0) begin failures++; $display("FAIL single_release rdy/val got %b%b want 10", req_rdy, rsp_val); end
    endtask

    task automatic test_multi_hit;
        int lat;
        write_entry(1, A2, 1, 1);
        write_entry(3, A2, 1, 1);
        do_req(A2, lat);
`ifdef TRI_ADDRCMP_SEQ_EARLY_EXIT_EN
        check_rsp("multi", lat, 3, 4'b0010, 2'd1);
`else
        check_rsp("multi", lat, 5, 4'b1010, 2'd1);
`endif
        ack();
    endtask

    task automatic test_lsb;
        int lat;
        write_entry(0, 36'h0_0000_0010, 0, 1);
        do_req(36'h0_0000_0011, lat);
`ifdef TRI_ADDRCMP_SEQ_EARLY_EXIT_EN
        check_rsp("lsb_ignored", lat, 2, 4'b0001, 2'd0);
`else
        check_rsp("lsb_ignored", lat, 5, 4'b0001, 2'd0);
`endif
        ack();
        write_entry(0, 36'h0_0000_0010, 1, 1);
        do_req(36'h0_0000_0011, lat);
        check_rsp("lsb_used", lat, 5, 4'b0000, 2'd0);
        ack();
    endtask

    task automatic test_backpressure;
        int lat;
        do_req(36'h0_0000_0010, lat);
        req_val = 1; req_addr = A1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_val !== 1 || rsp_hit_vec !== 4'b0001 || req_rdy !== 0) begin
                failures++;
                $display("FAIL hold val/vec/rdy got %b/%b/%b want 1/0001/0", rsp_val, rsp_hit_vec, req_rdy);
            end
        end
        rsp_rdy = 1;
        @(negedge clk);
        rsp_rdy = 0;
        checks++;
        if (req_rdy !== 1 || rsp_val !== 0) begin failures++; $display("FAIL hold_release rdy/val got %b%b want 10", req_rdy, rsp_val); end
        @(negedge clk);
        req_val = 0;
        checks++;
        if (busy !== 1 || req_rdy !== 0) begin failures++; $display("FAIL new_accept busy/rdy got %b%b want 10", busy, req_rdy); end
        wait_rsp(lat);
        check_rsp("after_hold", lat, 5, 4'b0100, 2'd2);
        ack();
    endtask

    task automatic test_flush;
        req_val = 1; req_addr = 36'h0_0000_0010;
        @(negedge clk);
        req_val = 0;
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks++;
        if (busy !== 0 || rsp_val !== 0 || req_rdy !== 1) begin
            failures++;
            $display("FAIL flush busy/val/rdy got %b%b%b want 001", busy, rsp_val, req_rdy);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (rsp_val !== 0) begin failures++; $display("FAIL flush_no_rsp rsp_val got %b want 0", rsp_val); end
        end
    endtask

    task automatic test_reset_mid_scan;
        int lat;
        req_val = 1; req_addr = A2;
        @(negedge clk);
        req_val = 0;
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks++;
        if (req_rdy !== 1 || busy !== 0 || rsp_val !== 0) begin
            failures++;
            $display("FAIL rst_scan rdy/busy/val got %b%b%b want 100", req_rdy, busy, rsp_val);
        end
        do_req(A2, lat);
        check_rsp("rst_cleared", lat, 5, 4'b0000, 2'd0);
        ack();
    endtask

    task automatic test_write_during_scan;
        int lat;
        req_val = 1; req_addr = AX;
        @(negedge clk);
        req_val = 0;
        write_entry(3, AX, 1, 1);
        wait_rsp(lat);
        check_rsp("late_write", lat + 1, 5, 4'b1000, 2'd3);
        ack();
        req_val = 1; req_addr = AY;
        @(negedge clk);
        req_val = 0;
        write_entry(0, AY, 1, 1);
        wait_rsp(lat);
        check_rsp("early_write", lat + 1, 5, 4'b0000, 2'd0);
        ack();
    endtask

    task automatic test_back_to_back;
        int t0, n;
        req_addr = AZ; req_val = 1; rsp_rdy = 1;
        n = 0;
        while (!req_rdy && n < 20) begin @(negedge clk); n++; end
        t0 = 0;
        @(negedge clk);
        t0++;
        while (!req_rdy && t0 < 20) begin @(negedge clk); t0++; end
        checks++;
        if (t0 !== 6) begin failures++; $display("FAIL back_to_back period got %0d want 6", t0); end
        req_val = 0;
        @(negedge clk);
        n = 0;
        while (busy && n < 20) begin @(negedge clk); n++; end
        rsp_rdy = 0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single_hit();
        test_multi_hit();
        test_lsb();
        test_backpressure();
        test_flush();
        test_reset_mid_scan();
        test_write_during_scan();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
